// File: rtl/qbus_reg_slave.sv
// Q-bus responder: small word-addressed register file with a CSR (DONE/IE) and
// one vectored interrupt source that joins the IAKO daisy chain.
module qbus_reg_slave #(
    parameter logic [15:0] BASE = 16'o177560,
    parameter int unsigned NREG = 4,
    parameter logic [8:0]  VEC  = 9'o060,
    parameter int unsigned WAIT = 0
) (
    input  logic        pin_clk,
    input  logic        pin_init_n,
    input  logic [15:0] pin_ad_in,
    output logic [15:0] pin_ad_out,
    output logic        pin_ad_ena,
    input  logic        pin_sync,
    input  logic        pin_din,
    input  logic        pin_dout,
    input  logic        pin_wtbt,
    output logic        pin_rply,
    output logic        pin_virq,
    input  logic        pin_iako_in,
    output logic        pin_iako_out,
    input  logic        pin_irq_set,
    output logic        csr_ie
);

    localparam int unsigned IW = $clog2(NREG);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StSkip,
        StWaits,
        StRply,
        StIak,
        StPass
    } state_e;

    state_e          state;
    logic            sync_prev;
    logic [IW-1:0]   idx;
    logic            bsel;
    logic            is_read;
    logic [2:0]      cnt;
    logic            done;
    logic            ie;
    logic            cond_prev;
    logic            irq_flag;
    logic [15:0]     data [NREG];

    logic [14:0]     offset;
    logic            addr_hit;
    logic            wr_commit;
    logic            wr_lo;
    logic            wr_hi;
    logic            csr_wr_lo;
    logic            irq_cond;
    logic [15:0]     rd_word;

    always_comb begin
        offset    = pin_ad_in[15:1] - BASE[15:1];
        // Addresses below BASE wrap to large offsets and fail the compare.
        addr_hit  = offset < 15'(NREG);
        wr_commit = (state == StWaits) && (cnt == 3'd0) && pin_sync && !is_read;
        wr_lo     = wr_commit && (!pin_wtbt || !bsel);
        wr_hi     = wr_commit && (!pin_wtbt || bsel);
        csr_wr_lo = wr_lo && (idx == '0);
        irq_cond  = done & ie;
        rd_word   = 16'h0000;
        if (idx == '0) begin
            rd_word = {8'h00, done, ie, 6'b000000};
        end else begin
            rd_word = data[idx];
        end
    end

    assign csr_ie = ie;

    always_ff @(posedge pin_clk) begin
        if (!pin_init_n) begin
            state        <= StIdle;
            sync_prev    <= 1'b0;
            idx          <= '0;
            bsel         <= 1'b0;
            is_read      <= 1'b0;
            cnt          <= 3'd0;
            done         <= 1'b0;
            ie           <= 1'b0;
            cond_prev    <= 1'b0;
            irq_flag     <= 1'b0;
            pin_ad_out   <= 16'h0000;
            pin_ad_ena   <= 1'b0;
            pin_rply     <= 1'b0;
            pin_virq     <= 1'b0;
            pin_iako_out <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                data[i] <= 16'h0000;
            end
        end else begin
            sync_prev <= pin_sync;
            cond_prev <= irq_cond;
            pin_virq  <= irq_flag;

            // DONE is only cleared by software; a same-cycle event keeps it set.
            if (csr_wr_lo) begin
                ie <= pin_ad_in[6];
            end
            done <= pin_irq_set | (done & ~(csr_wr_lo & ~pin_ad_in[7]));

            if (wr_commit && (idx != '0)) begin
                if (wr_lo) begin
                    data[idx][7:0] <= pin_ad_in[7:0];
                end
                if (wr_hi) begin
                    data[idx][15:8] <= pin_ad_in[15:8];
                end
            end

            if (!ie) begin
                irq_flag <= 1'b0;
            end else if (irq_cond && !cond_prev) begin
                irq_flag <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (pin_sync && !sync_prev) begin
                        idx   <= offset[IW-1:0];
                        bsel  <= pin_ad_in[0];
                        state <= addr_hit ? StAddr : StSkip;
                    end else if (!pin_sync && pin_din && pin_iako_in) begin
                        if (irq_flag) begin
                            state      <= StIak;
                            pin_ad_out <= {7'b0000000, VEC};
                            pin_ad_ena <= 1'b1;
                            pin_rply   <= 1'b1;
                            irq_flag   <= 1'b0;
                        end else begin
                            state        <= StPass;
                            pin_iako_out <= 1'b1;
                        end
                    end
                end
                StSkip: begin
                    if (!pin_sync) begin
                        state <= StIdle;
                    end
                end
                StAddr: begin
                    if (!pin_sync) begin
                        state <= StIdle;
                    end else if (pin_din || pin_dout) begin
                        is_read <= pin_din;
                        cnt     <= 3'(WAIT);
                        state   <= StWaits;
                    end
                end
                StWaits: begin
                    if (!pin_sync) begin
                        state <= StIdle;
                    end else if (cnt == 3'd0) begin
                        state    <= StRply;
                        pin_rply <= 1'b1;
                        if (is_read) begin
                            pin_ad_ena <= 1'b1;
                            pin_ad_out <= rd_word;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StRply: begin
                    if (!pin_sync) begin
                        state      <= StIdle;
                        pin_rply   <= 1'b0;
                        pin_ad_ena <= 1'b0;
                        pin_ad_out <= 16'h0000;
                    end else if (!pin_din && !pin_dout) begin
                        // Back to ADDR so a second strobe (DATIO) can follow.
                        state      <= StAddr;
                        pin_rply   <= 1'b0;
                        pin_ad_ena <= 1'b0;
                        pin_ad_out <= 16'h0000;
                    end
                end
                StIak: begin
                    if (!pin_iako_in || !pin_din) begin
                        state      <= StIdle;
                        pin_rply   <= 1'b0;
                        pin_ad_ena <= 1'b0;
                        pin_ad_out <= 16'h0000;
                    end
                end
                StPass: begin
                    if (!pin_iako_in) begin
                        state        <= StIdle;
                        pin_iako_out <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_reg_slave.sv
// Bench for qbus_reg_slave: random register traffic against an array model,
// then directed timing, byte-write, wait-state, interrupt and abort checks.
module tb_qbus_reg_slave;

    localparam logic [15:0] BASE0 = 16'o177560;
    localparam logic [15:0] BASE3 = 16'o177540;

    logic        clk = 1'b0;
    logic        init_n = 1'b0;
    logic [15:0] ad_in = 16'h0000;
    logic        sync = 1'b0, din = 1'b0, dout = 1'b0, wtbt = 1'b0;
    logic        iako_in = 1'b0, irq_set = 1'b0;

    logic [15:0] ad_out0, ad_out3;
    logic        ena0, ena3, rply0, rply3, virq0, virq3;
    logic        iako_out0, iako_out3, ie0, ie3;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_reg [4];
    logic        m_done, m_ie;

    always #5 clk = ~clk;

    qbus_reg_slave #(.BASE(BASE0), .NREG(4), .VEC(9'o060), .WAIT(0)) dut0 (
        .pin_clk(clk), .pin_init_n(init_n), .pin_ad_in(ad_in), .pin_ad_out(ad_out0),
        .pin_ad_ena(ena0), .pin_sync(sync), .pin_din(din), .pin_dout(dout),
        .pin_wtbt(wtbt), .pin_rply(rply0), .pin_virq(virq0), .pin_iako_in(iako_in),
        .pin_iako_out(iako_out0), .pin_irq_set(irq_set), .csr_ie(ie0)
    );

    qbus_reg_slave #(.BASE(BASE3), .NREG(4), .VEC(9'o070), .WAIT(3)) dut3 (
        .pin_clk(clk), .pin_init_n(init_n), .pin_ad_in(ad_in), .pin_ad_out(ad_out3),
        .pin_ad_ena(ena3), .pin_sync(sync), .pin_din(din), .pin_dout(dout),
        .pin_wtbt(wtbt), .pin_rply(rply3), .pin_virq(virq3), .pin_iako_in(iako_in),
        .pin_iako_out(iako_out3), .pin_irq_set(1'b0), .csr_ie(ie3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rply_of(input bit d3);
        return d3 ? rply3 : rply0;
    endfunction

    // One complete DATI/DATO/DATOB with a bounded wait for the reply.
    task automatic bus_cycle(input bit d3, input logic [15:0] addr, input bit write,
                             input bit bytef, input logic [15:0] wdata, input bit exp_reply,
                             output logic [15:0] rdata);
        int n;
        rdata = 16'h0000;
        ad_in = addr;
        wtbt  = write;
        sync  = 1'b1;
        tick();
        ad_in = write ? wdata : 16'h0000;
        wtbt  = bytef;
        if (write) dout = 1'b1; else din = 1'b1;
        n = 0;
        while (!rply_of(d3) && n < 20) begin
            tick();
            n++;
        end
        if (exp_reply) begin
            chk("reply", {15'h0, rply_of(d3)}, 16'h0001);
            rdata = d3 ? ad_out3 : ad_out0;
            if (write) chk("write_no_ena", {15'h0, d3 ? ena3 : ena0}, 16'h0000);
        end else begin
            chk("unselected_quiet", {14'h0, rply_of(d3), d3 ? ena3 : ena0}, 16'h0000);
        end
        din  = 1'b0;
        dout = 1'b0;
        tick();
        if (exp_reply) chk("rply_drop", {15'h0, rply_of(d3)}, 16'h0000);
        sync  = 1'b0;
        wtbt  = 1'b0;
        ad_in = 16'h0000;
        tick();
    endtask

    function automatic logic [15:0] model_read(input int i);
        return (i == 0) ? {8'h00, m_done, m_ie, 6'b0} : m_reg[i];
    endfunction

    // Byte writes take the bus byte that matches the addressed byte lane.
    task automatic model_write(input int i, input bit bytef, input bit b, input logic [15:0] d);
        logic [15:0] mask;
        mask = !bytef ? 16'hFFFF : (b ? 16'hFF00 : 16'h00FF);
        if (i == 0) begin
            if (mask[7]) begin
                m_ie = d[6];
                if (!d[7]) m_done = 1'b0;
            end
        end else begin
            m_reg[i] = (m_reg[i] & ~mask) | (d & mask);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
        m_done = 1'b0;
        m_ie   = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] d;
        int          i, op, n;
        bit          b;

        model_reset();
        tick();
        tick();
        init_n = 1'b1;
        chk("rst_ad_out", ad_out0, 16'h0000);
        chk("rst_flags0", {10'h0, ena0, rply0, virq0, iako_out0, ie0, 1'b0}, 16'h0000);
        chk("rst_flags3", {10'h0, ena3, rply3, virq3, iako_out3, ie3, 1'b0}, 16'h0000);

        for (int t = 0; t < 40; t++) begin
            i  = int'($urandom_range(0, 4));
            op = int'($urandom_range(0, 2));
            b  = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            if (i == 4) begin
                bus_cycle(1'b0, 16'o177570 + 16'(2 * $urandom_range(0, 3)), op != 0, 1'b0, d,
                          1'b0, rd);
            end else if (op == 0) begin
                bus_cycle(1'b0, BASE0 + 16'(2 * i), 1'b0, 1'b0, 16'h0, 1'b1, rd);
                chk("rand_read", rd, model_read(i));
            end else begin
                if (i == 0) d[7] = 1'b0;
                if (op == 1) b = 1'b0;
                bus_cycle(1'b0, BASE0 + 16'(2 * i) + 16'(b), 1'b1, op == 2, d, 1'b1, rd);
                model_write(i, op == 2, b, d);
            end
        end
        for (int k = 0; k < 4; k++) begin
            bus_cycle(1'b0, BASE0 + 16'(2 * k), 1'b0, 1'b0, 16'h0, 1'b1, rd);
            chk("rand_final", rd, model_read(k));
        end

        // DATI latency with WAIT=0.
        bus_cycle(1'b0, 16'o177562, 1'b1, 1'b0, 16'h1234, 1'b1, rd);
        ad_in = 16'o177562; wtbt = 1'b0; sync = 1'b1;
        tick();
        ad_in = 16'h0000; din = 1'b1;
        tick();
        chk("dati_early", {15'h0, rply0}, 16'h0000);
        tick();
        chk("dati_rply", {14'h0, rply0, ena0}, 16'h0003);
        chk("dati_data", ad_out0, 16'h1234);
        tick();
        chk("dati_hold", {15'h0, rply0}, 16'h0001);
        din = 1'b0;
        tick();
        chk("dati_release", {14'h0, rply0, ena0}, 16'h0000);
        sync = 1'b0;
        tick();

        // Byte writes into reg1.
        bus_cycle(1'b0, 16'o177563, 1'b1, 1'b1, 16'hAB00, 1'b1, rd);
        bus_cycle(1'b0, 16'o177562, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("datob_hi", rd, 16'hAB34);
        bus_cycle(1'b0, 16'o177562, 1'b1, 1'b1, 16'h00CD, 1'b1, rd);
        bus_cycle(1'b0, 16'o177562, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("datob_lo", rd, 16'hABCD);

        bus_cycle(1'b0, 16'o177600, 1'b0, 1'b0, 16'h0, 1'b0, rd);

        // WAIT=3: reply four cycles after the strobe is sampled.
        ad_in = 16'o177544; wtbt = 1'b1; sync = 1'b1;
        tick();
        ad_in = 16'h5A5A; wtbt = 1'b0; dout = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("wait3_early", {15'h0, rply3}, 16'h0000);
        tick();
        chk("wait3_rply", {15'h0, rply3}, 16'h0001);
        dout = 1'b0;
        tick();
        chk("wait3_drop", {15'h0, rply3}, 16'h0000);
        sync = 1'b0;
        tick();
        bus_cycle(1'b1, 16'o177544, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("wait3_data", rd, 16'h5A5A);

        // Sync dropped during wait states: no reply, no write.
        ad_in = 16'o177544; wtbt = 1'b1; sync = 1'b1;
        tick();
        ad_in = 16'hFFFF; wtbt = 1'b0; dout = 1'b1;
        tick();
        tick();
        sync = 1'b0; dout = 1'b0;
        tick();
        chk("abort_rply", {15'h0, rply3}, 16'h0000);
        tick();
        bus_cycle(1'b1, 16'o177544, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("abort_nowrite", rd, 16'h5A5A);

        // Interrupt request and acknowledge.
        bus_cycle(1'b0, BASE0, 1'b1, 1'b0, 16'h0040, 1'b1, rd);
        chk("csr_ie_out", {15'h0, ie0}, 16'h0001);
        irq_set = 1'b1;
        tick();
        irq_set = 1'b0;
        n = 0;
        while (!virq0 && n < 10) begin
            tick();
            n++;
        end
        chk("virq_set", {15'h0, virq0}, 16'h0001);
        din = 1'b1; iako_in = 1'b1;
        tick();
        chk("iak_vector", ad_out0, 16'o000060);
        chk("iak_flags", {13'h0, rply0, ena0, iako_out0}, 16'h0006);
        tick();
        chk("iak_virq_drop", {15'h0, virq0}, 16'h0000);
        din = 1'b0; iako_in = 1'b0;
        tick();
        chk("iak_release", {14'h0, rply0, ena0}, 16'h0000);
        din = 1'b1; iako_in = 1'b1;
        tick();
        chk("pass_iako", {14'h0, iako_out0, rply0}, 16'h0002);
        tick();
        chk("pass_norply", {14'h0, rply0, ena0}, 16'h0000);
        din = 1'b0; iako_in = 1'b0;
        tick();
        chk("pass_release", {15'h0, iako_out0}, 16'h0000);

        // Set beats a same-cycle clear of DONE.
        bus_cycle(1'b0, BASE0, 1'b1, 1'b0, 16'h0000, 1'b1, rd);
        bus_cycle(1'b0, BASE0, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("csr_cleared", rd, 16'h0000);
        ad_in = BASE0; wtbt = 1'b1; sync = 1'b1;
        tick();
        ad_in = 16'h0040; dout = 1'b1;
        tick();
        irq_set = 1'b1;
        tick();
        irq_set = 1'b0;
        chk("same_cycle_rply", {15'h0, rply0}, 16'h0001);
        dout = 1'b0;
        tick();
        sync = 1'b0; wtbt = 1'b0;
        tick();
        bus_cycle(1'b0, BASE0, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("same_cycle_csr", rd, 16'h00C0);

        // Reset in the middle of a reply.
        ad_in = 16'o177562; sync = 1'b1;
        tick();
        ad_in = 16'h0000; din = 1'b1;
        tick();
        tick();
        chk("pre_reset_rply", {15'h0, rply0}, 16'h0001);
        init_n = 1'b0;
        tick();
        chk("reset_rply", {13'h0, rply0, ena0, virq0}, 16'h0000);
        chk("reset_ad_out", ad_out0, 16'h0000);
        init_n = 1'b1; din = 1'b0; sync = 1'b0;
        tick();
        model_reset();
        bus_cycle(1'b0, 16'o177562, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("reset_reg1", rd, model_read(1));
        bus_cycle(1'b0, BASE0, 1'b0, 1'b0, 16'h0, 1'b1, rd);
        chk("reset_csr", rd, model_read(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
